rgb_mixer_n: RTL
================

Name: rgb_mixer_n

Overview:
Parametrised N-channel successor of the 3-channel RGB mixer. Each channel takes one quadrature encoder and produces one PWM output:
- inputs are synchronised, debounced and quadrature-decoded;
- the decoded value drives a step-sized level register with selectable saturate/wrap;
- the level feeds a glitch-free PWM.
All logic runs on the single input clock and is advanced by an internal tick enable; there is no derived clock. This block is the top of the mixer datapath.

Parameters:
NUM_CH, 3, number of encoder/PWM channels (1..16)
WIDTH, 8, level and PWM counter width in bits
HIST_LEN, 8, debounce history length in ticks (>=2)
DIV_BITS, 7, tick divider width; one tick every 2^DIV_BITS clk cycles
STEP, 1, level change per decoded detent (1..2^WIDTH-1)

Ports:
clk  input  1  system clock (12 MHz on board)
reset_n  input  1  asynchronous active-low reset
enc_a  input  NUM_CH  encoder A phases, bit i = channel i, asynchronous
enc_b  input  NUM_CH  encoder B phases, bit i = channel i, asynchronous
saturate  input  1  1 = clamp level at 0 / 2^WIDTH-1; 0 = wrap modulo 2^WIDTH; synchronous to clk
pwm_out  output  NUM_CH  PWM outputs, bit i = channel i
level_out  output  NUM_CH*WIDTH  live level registers, channel i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset: reset_n low asynchronously clears all state: tick counter, synchronisers, histories, debounced values, previous-phase registers, levels, PWM counter, shadow levels. pwm_out=0 and level_out=0 while in reset and on the first clk edge after release. Asserting reset mid-operation aborts everything; there is no retained state.
- Tick: a free-running DIV_BITS counter increments every clk. tick=1 for exactly one clk cycle when the counter is all-ones. The first tick after reset is at clk cycle 2^DIV_BITS-1.
- Sync: a 2-flop synchroniser per enc_a/enc_b bit, clocked every clk (not tick-gated).
- Debounce, per phase, on tick:
  - hist <= {hist[HIST_LEN-2:0], sync}.
  - db <= 1 if the new hist is all ones; db <= 0 if it is all zeros; otherwise db holds.
  - A stable input therefore changes db on the HIST_LEN-th tick after it reaches sync.
- Decode, per channel, on tick: compare db_a/db_b with registered prev_a/prev_b, then prev <= db.
  - Only A changed: if db_a != db_b the direction is up (+STEP), else down (-STEP). This is x2 decoding, one event per A edge.
  - Only B changed, or neither changed: no event.
  - Both changed on the same tick: illegal transition, ignored (no event, prev still updated).
  - The event is applied to the level on the tick after db changes.
- Level arithmetic, WIDTH bits, computed in WIDTH+1 bits:
  - saturate=1: up clamps at 2^WIDTH-1; down clamps at 0.
  - saturate=0: result taken modulo 2^WIDTH.
  - saturate is sampled on the same tick as the event.
  - level_out reflects the level register directly.
- PWM (one counter shared by all channels, WIDTH bits, increments on tick):
  - Per-channel shadow level loads from the level register on the tick where the counter wraps from 2^WIDTH-1 to 0. Level changes therefore never alter the current period.
  - pwm_out[i] is registered: high when counter < shadow[i]. It updates on the clk edge of each tick, using the counter and shadow values that hold after that edge.
  - Duty = shadow/2^WIDTH. Level 0 means constant low; 2^WIDTH-1 means low for 1 tick per period.
  - Period = 2^WIDTH ticks. New levels take effect within 1 period plus 1 tick.
- Channels are fully independent. Simultaneous events on different channels are all applied on the same tick.

Decomposition:
- Shared package/include rgb_mixer_pkg holds:
  - default parameter constants;
  - direction encoding DIR_NONE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10;
  - the level slice helper macro.
- One sub-module, rgb_mixer_channel, contains sync + debounce + decode + level + shadow + compare for one channel. It receives tick, the shared PWM counter and the counter-wrap strobe. rgb_mixer_n owns the divider and the PWM counter and instantiates NUM_CH channels with a generate loop.

Test Plan:
All scenarios use DIV_BITS=2 and HIST_LEN=4.
1. Reset: hold reset_n low 10 cycles with enc toggling, then release -> pwm_out=0 and level_out=0 throughout; first tick at cycle 3 after release.
2. Clockwise: ch0 from A=0,B=0, raise A then B, 5 detents (stable 8 ticks each) -> level_out ch0 = 5*STEP = 5. Each increment lands exactly 5 ticks after the A edge reaches sync (4 debounce + 1 decode).
3. Boundaries: saturate=1, ch1 at 0 with 3 down detents -> stays 0. Then saturate=0 with 1 down detent -> 255. Then 1 up detent -> 0. With saturate=1 at 255, 1 up -> stays 255.
4. Bounce: pulse enc_a[0] high for 3 ticks then low, repeated -> db never changes, level unchanged. Both A and B changed in the same tick -> no event.
5. PWM: ch2 level set to 64 mid-period -> the current period keeps its old duty. The next period has pwm_out[2] high exactly 64 of 256 ticks. Level 0 -> pwm_out[2] constantly low.
6. Multi-channel: NUM_CH=4, WIDTH=6, STEP=3; one up detent on all channels in the same tick -> every level_out slice = 3; channels then diverge independently.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
// rgb_mixer_pkg
// Shared definitions for the N-channel RGB mixer datapath.
//   - Default parameter values used by rgb_mixer_n and rgb_mixer_channel.
//   - Direction encoding produced by the quadrature decoder.
//   - decodeDir(): one-step x2 quadrature decode from previous/current phases.
//   - RGB_LEVEL_SLICE: part-select of channel ch in a packed level bus of
//     w-bit fields, e.g. bus[`RGB_LEVEL_SLICE(i, WIDTH)].
`ifndef RGB_MIXER_PKG_SV
`define RGB_MIXER_PKG_SV

`define RGB_LEVEL_SLICE(ch, w) ((ch) * (w)) +: (w)

package rgb_mixer_pkg;

    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_HIST_LEN = 8;
    localparam int DEF_DIV_BITS = 7;
    localparam int DEF_STEP     = 1;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    // Only an A edge with B steady is a detent. Simultaneous A and B edges
    // are an impossible quadrature step (missed sample) and are dropped.
    function automatic dir_e decodeDir(input logic prevA, input logic prevB,
                                       input logic curA, input logic curB);
        dir_e dir;
        dir = DIR_NONE;
        if ((curA != prevA) && (curB == prevB)) begin
            dir = (curA != curB) ? DIR_UP : DIR_DOWN;
        end
        return dir;
    endfunction

endpackage

`endif

// File: rtl/rgb_mixer_channel.sv
// rgb_mixer_channel
// One encoder-to-PWM channel: 2-flop synchroniser, history debounce,
// x2 quadrature decode, step-sized level register (saturate or wrap),
// per-period shadow level and registered PWM compare.
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   tick_i          one-cycle enable that advances debounce/decode/PWM
//   wrap_i          tick on which the shared PWM counter rolls over to 0
//   pwmCntNext_i    shared PWM counter value after this tick's edge
//   encA_i, encB_i  raw asynchronous encoder phases
//   saturate_i      1 = clamp level, 0 = wrap modulo 2^WIDTH
//   level_o         live level register
//   pwm_o           registered PWM output
module rgb_mixer_channel
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HIST_LEN = DEF_HIST_LEN,
    parameter int STEP     = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             wrap_i,
    input  logic [WIDTH-1:0] pwmCntNext_i,
    input  logic             encA_i,
    input  logic             encB_i,
    input  logic             saturate_i,
    output logic [WIDTH-1:0] level_o,
    output logic             pwm_o
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    logic [1:0]          syncA_q, syncB_q;
    logic [HIST_LEN-1:0] histA_q, histA_d;
    logic [HIST_LEN-1:0] histB_q, histB_d;
    logic                dbA_q, dbA_d, dbB_q, dbB_d;
    logic                prevA_q, prevA_d, prevB_q, prevB_d;
    logic [WIDTH-1:0]    level_q, level_d;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic                pwm_q, pwm_d;
    logic [WIDTH:0]      upSum, dnDiff;
    dir_e                dir;

    // Synchronisers run on every clk so the tick only sees settled values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[0], encA_i};
            syncB_q <= {syncB_q[0], encB_i};
        end
    end

    // Decode compares the debounced values already registered against prev,
    // so a detent reaches the level one tick after db changes.
    // Shadow captures the pre-update level on the wrap tick, and the PWM
    // compare uses the counter/shadow values that hold after this edge.
    always_comb begin
        histA_d  = histA_q;
        histB_d  = histB_q;
        dbA_d    = dbA_q;
        dbB_d    = dbB_q;
        prevA_d  = prevA_q;
        prevB_d  = prevB_q;
        level_d  = level_q;
        shadow_d = shadow_q;
        pwm_d    = pwm_q;
        dir      = DIR_NONE;
        upSum    = {1'b0, level_q} + STEP_EXT;
        dnDiff   = {1'b0, level_q} - STEP_EXT;
        if (tick_i) begin
            histA_d = {histA_q[HIST_LEN-2:0], syncA_q[1]};
            histB_d = {histB_q[HIST_LEN-2:0], syncB_q[1]};
            if (&histA_d) begin
                dbA_d = 1'b1;
            end else if (~|histA_d) begin
                dbA_d = 1'b0;
            end
            if (&histB_d) begin
                dbB_d = 1'b1;
            end else if (~|histB_d) begin
                dbB_d = 1'b0;
            end
            dir     = decodeDir(prevA_q, prevB_q, dbA_q, dbB_q);
            prevA_d = dbA_q;
            prevB_d = dbB_q;
            // Bit WIDTH of the extended sum/difference flags carry/borrow.
            case (dir)
                DIR_UP:   level_d = (upSum[WIDTH] && saturate_i) ? '1 : upSum[WIDTH-1:0];
                DIR_DOWN: level_d = (dnDiff[WIDTH] && saturate_i) ? '0 : dnDiff[WIDTH-1:0];
                default:  level_d = level_q;
            endcase
            if (wrap_i) begin
                shadow_d = level_q;
            end
            pwm_d = (pwmCntNext_i < shadow_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            histA_q  <= '0;
            histB_q  <= '0;
            dbA_q    <= 1'b0;
            dbB_q    <= 1'b0;
            prevA_q  <= 1'b0;
            prevB_q  <= 1'b0;
            level_q  <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            histA_q  <= histA_d;
            histB_q  <= histB_d;
            dbA_q    <= dbA_d;
            dbB_q    <= dbB_d;
            prevA_q  <= prevA_d;
            prevB_q  <= prevB_d;
            level_q  <= level_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign level_o = level_q;
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/rgb_mixer_n.sv
// rgb_mixer_n
// Top of the N-channel mixer datapath. Owns the tick divider and the PWM
// counter shared by all channels, and instantiates NUM_CH channels.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   enc_a      encoder A phases, bit i = channel i (asynchronous)
//   enc_b      encoder B phases, bit i = channel i (asynchronous)
//   saturate   1 = clamp levels, 0 = wrap modulo 2^WIDTH
//   pwm_out    PWM outputs, bit i = channel i
//   level_out  live levels, channel i at [i*WIDTH +: WIDTH]
module rgb_mixer_n
    import rgb_mixer_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HIST_LEN = DEF_HIST_LEN,
    parameter int DIV_BITS = DEF_DIV_BITS,
    parameter int STEP     = DEF_STEP
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic                    saturate,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH*WIDTH-1:0] level_out
);

    logic [DIV_BITS-1:0] divCnt_q;
    logic [WIDTH-1:0]    pwmCnt_q, pwmCnt_d;
    logic                tick;
    logic                wrap;

    // Tick is the all-ones state of the free-running divider; wrap marks
    // the tick on which the PWM counter rolls over to start a new period.
    assign tick     = &divCnt_q;
    assign wrap     = tick && (&pwmCnt_q);
    assign pwmCnt_d = tick ? (pwmCnt_q + 1'b1) : pwmCnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divCnt_q <= '0;
            pwmCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + 1'b1;
            pwmCnt_q <= pwmCnt_d;
        end
    end

    // Channels receive the post-edge counter so their registered compare
    // matches the counter value that holds after the tick.
    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        rgb_mixer_channel #(
            .WIDTH   (WIDTH),
            .HIST_LEN(HIST_LEN),
            .STEP    (STEP)
        ) uChannel (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick_i      (tick),
            .wrap_i      (wrap),
            .pwmCntNext_i(pwmCnt_d),
            .encA_i      (enc_a[g]),
            .encB_i      (enc_b[g]),
            .saturate_i  (saturate),
            .level_o     (level_out[`RGB_LEVEL_SLICE(g, WIDTH)]),
            .pwm_o       (pwm_out[g])
        );
    end

endmodule
